// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : stall/flush controller for the 5-stage pipeline (load-use, multi-cycle mult, taken-branch squash).
// Latency : control outputs are combinational, same cycle as inputs; FSM and stall counter update on clk rising edge.
// Backpr. : stalls the PC and IF/ID and injects bubbles. Priority is branch flush > multiply > load-use.
// Ports   : ID operand fields/uses, EX load/dest/mult-start, MEM taken branch in;
//           PC/IFID/IDEX write enables, IFID/IDEX/EXMEM flushes, MultBusy/MultDone and StallCount out.
module pipeline_hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             IDrsReg,
    input  logic [4:0]             IDrtReg,
    input  logic                   IDUsesRs,
    input  logic                   IDUsesRt,
    input  logic                   EXMemRead,
    input  logic [4:0]             EXrdReg,
    input  logic                   EXMultStart,
    input  logic                   MEMBranchTaken,
    output logic                   PCWrite,
    output logic                   IFIDWrite,
    output logic                   IFIDFlush,
    output logic                   IDEXWrite,
    output logic                   IDEXFlush,
    output logic                   EXMEMFlush,
    output logic                   MultBusy,
    output logic                   MultDone,
    output logic [STALL_CNT_W-1:0] StallCount
);

    typedef enum logic {IDLE = 1'b0, MULT = 1'b1} state_t;

    // mcnt counts the EX cycles already spent; the last one releases the pipeline.
    localparam logic [3:0] MCNT_LAST = 4'(MULT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [3:0]             mcnt_q, mcnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   load_use;

    // $0 is hardwired to zero, so a load that targets it can never create a dependency.
    assign load_use = EXMemRead && (EXrdReg != 5'd0) &&
                      ((IDUsesRs && (IDrsReg == EXrdReg)) ||
                       (IDUsesRt && (IDrtReg == EXrdReg)));

    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXWrite   = 1'b1;
        IDEXFlush   = 1'b0;
        EXMEMFlush  = 1'b0;
        MultDone    = 1'b0;
        MultBusy    = (state_q == MULT);
        state_d     = state_q;
        mcnt_d      = mcnt_q;
        stall_cnt_d = stall_cnt_q;

        if (MEMBranchTaken) begin
            // Everything younger than MEM is wrong-path, including any multiply in EX.
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
            state_d    = IDLE;
            mcnt_d     = 4'd0;
        end else if (state_q == MULT) begin
            // EXMultStart is ignored here so a mult held in EX does not retrigger.
            if (mcnt_q == MCNT_LAST) begin
                MultDone = 1'b1;
                state_d  = IDLE;
                mcnt_d   = 4'd0;
            end else begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXWrite  = 1'b0;
                EXMEMFlush = 1'b1;
                mcnt_d     = mcnt_q + 4'd1;
            end
        end else if (EXMultStart) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMFlush = 1'b1;
            state_d    = MULT;
            mcnt_d     = 4'd1;
        end else if (load_use) begin
            // Hold IF/ID and the PC; ID/EX still loads, but it loads a bubble.
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end

        if (!PCWrite && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end

        // While in reset the pipeline must see a benign, free-running control word.
        if (!rst_n) begin
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IFIDFlush  = 1'b0;
            IDEXWrite  = 1'b1;
            IDEXFlush  = 1'b0;
            EXMEMFlush = 1'b0;
            MultBusy   = 1'b0;
            MultDone   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcnt_q      <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mcnt_q      <= mcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] IDrsReg, IDrtReg, EXrdReg;
    logic       IDUsesRs, IDUsesRt, EXMemRead, EXMultStart, MEMBranchTaken;

    logic        pcw, ifidw, ifidf, idexw, idexf, exmemf, busy, done;
    logic [15:0] cnt;
    logic        pcw2, ifidw2, ifidf2, idexw2, idexf2, exmemf2, busy2, done2;
    logic [15:0] cnt2;
    logic        pcws, ifidws, ifidfs, idexws, idexfs, exmemfs, busys, dones;
    logic [3:0]  cnts;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    // Control word order: PCWrite IFIDWrite IFIDFlush IDEXWrite IDEXFlush EXMEMFlush MultBusy MultDone
    localparam logic [7:0] C_NORM   = 8'b1101_0000;
    localparam logic [7:0] C_LU     = 8'b0001_1000;
    localparam logic [7:0] C_MSTART = 8'b0000_0100;
    localparam logic [7:0] C_MSTALL = 8'b0000_0110;
    localparam logic [7:0] C_MDONE  = 8'b1101_0011;
    localparam logic [7:0] C_BR_M   = 8'b1111_1110;
    localparam logic [7:0] C_BR_I   = 8'b1111_1100;

    logic [7:0] ctl, ctl2;
    assign ctl  = {pcw, ifidw, ifidf, idexw, idexf, exmemf, busy, done};
    assign ctl2 = {pcw2, ifidw2, ifidf2, idexw2, idexf2, exmemf2, busy2, done2};

    pipeline_hazard_ctrl #(.MULT_CYCLES(4), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .IDrsReg(IDrsReg), .IDrtReg(IDrtReg),
        .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt), .EXMemRead(EXMemRead), .EXrdReg(EXrdReg),
        .EXMultStart(EXMultStart), .MEMBranchTaken(MEMBranchTaken),
        .PCWrite(pcw), .IFIDWrite(ifidw), .IFIDFlush(ifidf), .IDEXWrite(idexw),
        .IDEXFlush(idexf), .EXMEMFlush(exmemf), .MultBusy(busy), .MultDone(done),
        .StallCount(cnt));

    pipeline_hazard_ctrl #(.MULT_CYCLES(2), .STALL_CNT_W(16)) dut_m2 (
        .clk(clk), .rst_n(rst_n), .IDrsReg(IDrsReg), .IDrtReg(IDrtReg),
        .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt), .EXMemRead(EXMemRead), .EXrdReg(EXrdReg),
        .EXMultStart(EXMultStart), .MEMBranchTaken(MEMBranchTaken),
        .PCWrite(pcw2), .IFIDWrite(ifidw2), .IFIDFlush(ifidf2), .IDEXWrite(idexw2),
        .IDEXFlush(idexf2), .EXMEMFlush(exmemf2), .MultBusy(busy2), .MultDone(done2),
        .StallCount(cnt2));

    pipeline_hazard_ctrl #(.MULT_CYCLES(4), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .IDrsReg(IDrsReg), .IDrtReg(IDrtReg),
        .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt), .EXMemRead(EXMemRead), .EXrdReg(EXrdReg),
        .EXMultStart(EXMultStart), .MEMBranchTaken(MEMBranchTaken),
        .PCWrite(pcws), .IFIDWrite(ifidws), .IFIDFlush(ifidfs), .IDEXWrite(idexws),
        .IDEXFlush(idexfs), .EXMEMFlush(exmemfs), .MultBusy(busys), .MultDone(dones),
        .StallCount(cnts));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        IDrsReg = 5'd0; IDrtReg = 5'd0; IDUsesRs = 1'b0; IDUsesRt = 1'b0;
        EXMemRead = 1'b0; EXrdReg = 5'd0; EXMultStart = 1'b0; MEMBranchTaken = 1'b0;
    endtask

    // Move to 1ns after the next rising edge; inputs change and outputs are sampled away from the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        cyc();
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        EXMemRead = 1'b1; EXrdReg = 5'd8; IDrsReg = 5'd8; IDUsesRs = 1'b1;
        EXMultStart = 1'b1;
        #2;
        checks++;
        if (ctl !== C_NORM) begin
            errors++; $display("FAIL reset_ctl: got %b want %b", ctl, C_NORM);
        end
        cyc();
        checks++;
        if (cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", cnt);
        end
        clear_inputs();
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctl !== C_NORM) begin
            errors++; $display("FAIL reset_release_ctl: got %b want %b", ctl, C_NORM);
        end
        cyc();
        checks++;
        if (cnt !== 16'd0) begin
            errors++; $display("FAIL reset_idle_cnt: got %0d want 0", cnt);
        end
        exp_cnt = 0;
    endtask

    task automatic test_load_use();
        // Four patterns: rs match, rd=$0, rt match, rs match but rs unused.
        logic [4:0] rd_t [4] = '{5'd8, 5'd0, 5'd17, 5'd5};
        logic       urs_t[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       urt_t[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [4:0] rt_t [4] = '{5'd3, 5'd0, 5'd17, 5'd6};
        logic       hz_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            EXMemRead = 1'b1; EXrdReg = rd_t[i];
            IDrsReg = rd_t[i]; IDUsesRs = urs_t[i];
            IDrtReg = rt_t[i]; IDUsesRt = urt_t[i];
            #1;
            checks++;
            if (ctl !== (hz_t[i] ? C_LU : C_NORM)) begin
                errors++; $display("FAIL load_use_ctl[%0d]: got %b want %b", i, ctl, hz_t[i] ? C_LU : C_NORM);
            end
            cyc();
            if (hz_t[i]) exp_cnt++;
            checks++;
            if (cnt !== 16'(exp_cnt)) begin
                errors++; $display("FAIL load_use_cnt[%0d]: got %0d want %0d", i, cnt, exp_cnt);
            end
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        EXMemRead = 1'b1; EXrdReg = 5'd9; IDrsReg = 5'd9; IDUsesRs = 1'b1;
        #1;
        checks++;
        if (ctl !== C_LU) begin
            errors++; $display("FAIL b2b_first: got %b want %b", ctl, C_LU);
        end
        cyc();
        // Bubble now in EX: the stalled consumer proceeds.
        clear_inputs();
        IDrsReg = 5'd9; IDUsesRs = 1'b1;
        #1;
        checks++;
        if (ctl !== C_NORM) begin
            errors++; $display("FAIL b2b_bubble: got %b want %b", ctl, C_NORM);
        end
        cyc();
        clear_inputs();
        EXMemRead = 1'b1; EXrdReg = 5'd10; IDrtReg = 5'd10; IDUsesRt = 1'b1;
        #1;
        checks++;
        if (ctl !== C_LU) begin
            errors++; $display("FAIL b2b_second: got %b want %b", ctl, C_LU);
        end
        cyc();
        exp_cnt += 2;
        checks++;
        if (cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL b2b_cnt: got %0d want %0d", cnt, exp_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_mult();
        logic [7:0] exp4[5] = '{C_MSTART, C_MSTALL, C_MSTALL, C_MDONE, C_NORM};
        logic [7:0] exp2[5] = '{C_MSTART, C_MDONE, C_MSTART, C_MDONE, C_NORM};
        do_reset();
        EXMultStart = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) EXMultStart = 1'b0;
            #1;
            checks++;
            if (ctl !== exp4[c]) begin
                errors++; $display("FAIL mult4_cycle%0d: got %b want %b", c, ctl, exp4[c]);
            end
            checks++;
            if (ctl2 !== exp2[c]) begin
                errors++; $display("FAIL mult2_cycle%0d: got %b want %b", c, ctl2, exp2[c]);
            end
            cyc();
        end
        exp_cnt = 3;
        checks++;
        if (cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL mult_cnt: got %0d want %0d", cnt, exp_cnt);
        end
    endtask

    task automatic test_branch_abort();
        logic [7:0] expb[5] = '{C_MSTART, C_MSTALL, C_BR_M, C_NORM, C_NORM};
        do_reset();
        EXMultStart = 1'b1;
        for (int c = 0; c < 5; c++) begin
            MEMBranchTaken = (c == 2);
            if (c >= 3) EXMultStart = 1'b0;
            #1;
            checks++;
            if (ctl !== expb[c]) begin
                errors++; $display("FAIL branch_abort_cycle%0d: got %b want %b", c, ctl, expb[c]);
            end
            cyc();
        end
        exp_cnt = 2;
        checks++;
        if (cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL branch_abort_cnt: got %0d want %0d", cnt, exp_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_mult();
        do_reset();
        EXMultStart = 1'b1;
        cyc();
        cyc();
        // Now in MULT with mcnt=2: stall word expected before reset hits.
        #1;
        checks++;
        if (ctl !== C_MSTALL) begin
            errors++; $display("FAIL rst_mid_pre: got %b want %b", ctl, C_MSTALL);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl !== C_NORM) begin
            errors++; $display("FAIL rst_mid_ctl: got %b want %b", ctl, C_NORM);
        end
        checks++;
        if (cnt !== 16'd0) begin
            errors++; $display("FAIL rst_mid_cnt: got %0d want 0", cnt);
        end
        cyc();
        clear_inputs();
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctl !== C_NORM) begin
            errors++; $display("FAIL rst_mid_release: got %b want %b", ctl, C_NORM);
        end
        cyc();
        exp_cnt = 0;
        checks++;
        if (cnt !== 16'd0) begin
            errors++; $display("FAIL rst_mid_idle_cnt: got %0d want 0", cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        EXMemRead = 1'b1; EXrdReg = 5'd12; IDrtReg = 5'd12; IDUsesRt = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            checks++;
            if (cnts !== 4'((i > 15) ? 15 : i)) begin
                errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, cnts, (i > 15) ? 15 : i);
            end
        end
        exp_cnt = 20;
        checks++;
        if (cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL sat_wide_cnt: got %0d want %0d", cnt, exp_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_branch_load_use();
        clear_inputs();
        EXMemRead = 1'b1; EXrdReg = 5'd8; IDrsReg = 5'd8; IDUsesRs = 1'b1;
        MEMBranchTaken = 1'b1;
        #1;
        checks++;
        if (ctl !== C_BR_I) begin
            errors++; $display("FAIL branch_lu_ctl: got %b want %b", ctl, C_BR_I);
        end
        cyc();
        checks++;
        if (cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL branch_lu_cnt: got %0d want %0d", cnt, exp_cnt);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_back_to_back();
        test_mult();
        test_branch_abort();
        test_reset_mid_mult();
        test_saturation();
        test_branch_load_use();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. Detects load-use hazards, sequences the multi-cycle multiplier occupying EX, and squashes wrong-path instructions when a branch resolves taken in MEM. Drives the PC write enable, the IF/ID write and flush, the ID/EX write and flush, and the EX/MEM flush. Also keeps a saturating stall-cycle counter for performance debug.

## Interface
- MULT_CYCLES, 4, number of cycles a multiply occupies EX; legal range 2..16
- STALL_CNT_W, 16, width of the stall performance counter
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- IDrsReg  in  5  rs field of the instruction in ID
- IDrtReg  in  5  rt field of the instruction in ID
- IDUsesRs  in  1  ID instruction reads rs
- IDUsesRt  in  1  ID instruction reads rt
- EXMemRead  in  1  instruction in EX is a load
- EXrdReg  in  5  destination register of the instruction in EX
- EXMultStart  in  1  instruction in EX is a mult/multu
- MEMBranchTaken  in  1  branch in MEM resolved taken (Branch and Zero qualified upstream)
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register load enable
- IFIDFlush  out  1  IF/ID clear to bubble
- IDEXWrite  out  1  ID/EX register load enable
- IDEXFlush  out  1  ID/EX clear to bubble
- EXMEMFlush  out  1  EX/MEM clear to bubble (drives its flush input)
- MultBusy  out  1  high while the multiply FSM is in MULT
- MultDone  out  1  high in the final EX cycle of a multiply; qualifies HiLoWrite
- StallCount  out  STALL_CNT_W  saturating count of cycles with PCWrite low

## Operation
- FSM states: IDLE, MULT. The 4-bit counter mcnt is valid in MULT only.
- Priority each cycle: branch flush > multiply sequencing > load-use.
- Branch flush: when MEMBranchTaken=1, assert IFIDFlush, IDEXFlush and EXMEMFlush, and keep PCWrite, IFIDWrite and IDEXWrite at 1. An in-flight multiply is on the wrong path, so it is aborted: FSM goes to IDLE, mcnt=0, and MultDone stays 0.
- Multiply sequencing, in IDLE: when EXMultStart=1 and there is no branch flush, stall this cycle (PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMFlush=1). Next state is MULT with mcnt=1.
- Multiply sequencing, in MULT with mcnt<MULT_CYCLES-1: the same stall outputs; mcnt increments.
- Multiply sequencing, in MULT with mcnt==MULT_CYCLES-1: no stall, MultDone=1 and EX/MEM captures the result. Next state is IDLE. EXMultStart is ignored in MULT, so a held mult does not retrigger.
- Load-use: the hazard fires when EXMemRead=1, EXrdReg!=0, and either (IDUsesRs and IDrsReg==EXrdReg) or (IDUsesRt and IDrtReg==EXrdReg).
- Load-use response: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IDEXWrite=1. This inserts exactly one bubble. It is combinational and has no state.
- Register $0 never causes a hazard.
- StallCount increments on every edge where PCWrite was 0 and saturates at all-ones. Branch-flush cycles do not count.
- MultBusy = (state==MULT).

## Timing
- Reset (rst_n low, async): state=IDLE, mcnt=0, StallCount=0.
- Outputs while rst_n is low, regardless of inputs: PCWrite=1, IFIDWrite=1, IDEXWrite=1, all flushes 0, MultBusy=0, MultDone=0.
- Deassertion of rst_n is synchronised externally. The first active edge after release evaluates normally.
- Control outputs are combinational from inputs and state, and are valid in the same cycle as the inputs.
- The multiply holds EX for exactly MULT_CYCLES cycles:
  - MULT_CYCLES-1 stalled cycles, with EX/MEM receiving bubbles;
  - then one release cycle with MultDone=1.
- Load-use costs exactly 1 cycle. Back-to-back loads feeding consecutive consumers each cost 1 cycle.
- A branch flush during any MULT cycle takes effect the same cycle. There is no stall that cycle, and the FSM is in IDLE on the next edge.
- Reset asserted mid-multiply forces IDLE immediately. No MultDone pulse is produced.
- Simultaneous EXMultStart and load-use cannot occur legally. If they do, the multiply path wins and IDEXFlush stays 0.

## Test plan
- Load-use: EX `lw rd=8`, ID `add` with rs=8 and IDUsesRs=1 -> one cycle of PCWrite=0, IFIDWrite=0, IDEXFlush=1; StallCount 0->1. Repeat with rd=0 -> no stall.
- Multiply, MULT_CYCLES=4: EXMultStart held from cycle 0 -> PCWrite=0 and EXMEMFlush=1 in cycles 0-2; MultBusy=1 in cycles 1-3; MultDone=1 in cycle 3 only; state IDLE at cycle 4; StallCount=3.
- Branch abort: start a multiply, assert MEMBranchTaken in cycle 2 -> all three flushes=1 and PCWrite=1 that cycle, MultDone never pulses, MultBusy=0 from cycle 3, StallCount=2.
- Reset mid-multiply: drop rst_n in MULT with mcnt=2 -> outputs go to reset values without a clock edge; StallCount=0; after release, an idle pipeline gives no stall.
- Saturation: STALL_CNT_W=4, 20 consecutive load-use stalls -> StallCount=15 and holds.
- Branch plus load-use in the same cycle: MEMBranchTaken=1 with a load-use match -> branch-flush outputs only (PCWrite=1, IDEXFlush=1); StallCount unchanged.
